pe_reg_loader: RTL and testbench

- Host-side initiator for one PE register file, used to preload registers before a run and to dump them afterwards.
- Load mode: accepts a valid/ready stream of 32-bit words and writes them into consecutive register indices through the PE bus input, using the ld/ld_write write-enable path.
- Dump mode: selects consecutive registers onto the PE bus output, captures each value and returns it on an outgoing valid/ready stream.
- Sits between the array configuration/host interface and the PE register file bus port.

---
 rtl/pe_reg_loader_if.sv | 46 ++++
 rtl/pe_reg_loader.sv | 150 +++++++++++++++
 tb/tb_pe_reg_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_reg_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pe_reg_loader_if
// Description : Bundles the host load/dump streams and the PE register-file
//               bus port of the PE register loader.
//               master : loader side (accepts s_*, produces m_*, drives pe_*)
//               slave  : host + PE side
//   s_valid/s_ready/s_data   load word stream into the loader
//   m_valid/m_ready/m_data   dump word stream out of the loader
//   pe_*                     PE register-file bus port
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface pe_reg_loader_if #(
   parameter int DW = 32,
   parameter int AW = 6
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [DW-1:0] pe_bus_in;
   logic [8:0]    pe_control_in;
   logic [AW-1:0] pe_control_put_in;
   logic          pe_ld;
   logic          pe_ld_write;
   logic [AW-1:0] pe_control_send;
   logic [8:0]    pe_control_out;
   logic [DW-1:0] pe_bus_out;

   modport master (
      input  s_valid, s_data, m_ready, pe_bus_out,
      output s_ready, m_valid, m_data, pe_bus_in, pe_control_in,
             pe_control_put_in, pe_ld, pe_ld_write, pe_control_send,
             pe_control_out
   );

   modport slave (
      output s_valid, s_data, m_ready, pe_bus_out,
      input  s_ready, m_valid, m_data, pe_bus_in, pe_control_in,
             pe_control_put_in, pe_ld, pe_ld_write, pe_control_send,
             pe_control_out
   );
endinterface
`default_nettype wire

// File: rtl/pe_reg_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pe_reg_loader
// Description : Host-side initiator for one PE register file. Load mode
//               writes a stream of words into consecutive register indices;
//               dump mode reads consecutive registers back out as a stream.
//   CLK        system clock (rising edge)
//   RST_N      synchronous active-low reset
//   start_load one-cycle load request, sampled in IDLE (wins over dump)
//   start_dump one-cycle dump request, sampled in IDLE
//   base_idx   first register index, sampled with start
//   count      word count 0..64 (larger values clamp to 64)
//   busy       high whenever not IDLE
//   done       one-cycle pulse at end of operation
//   bus        streams + PE bus port (pe_reg_loader_if.master)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pe_reg_loader #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            start_load,
   input  logic            start_dump,
   input  logic [AW-1:0]   base_idx,
   input  logic [AW:0]     count,
   output logic            busy,
   output logic            done,
   pe_reg_loader_if.master bus
);
   localparam logic [8:0]    C_SEL_BUS = 9'b000010000;
   localparam logic [AW:0]   C_MAX_CNT = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   C_REM_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] C_IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_DUMP_SEL = 3'd2,
      S_DUMP_OUT = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_idx;
   logic [AW:0]   r_rem;
   logic [DW-1:0] r_bus_in;
   logic [AW-1:0] r_put_in;
   logic          r_ld_write;
   logic [8:0]    r_control_in;
   logic [DW-1:0] r_m_data;
   logic          r_m_valid;
   logic [AW:0]   w_clamp;
   logic          w_s_ready;
   logic          w_s_fire;
   logic          w_m_fire;

   assign w_clamp   = (count > C_MAX_CNT) ? C_MAX_CNT : count;
   // After the last word is accepted LOAD lingers one cycle with rem==0 so the
   // final registered strobe finishes before DONE; s_ready is already low.
   assign w_s_ready = (r_state == S_LOAD) && (r_rem != '0);
   assign w_s_fire  = w_s_ready && bus.s_valid;
   assign w_m_fire  = (r_state == S_DUMP_OUT) && r_m_valid && bus.m_ready;

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start_load)
               w_next = (w_clamp == '0) ? S_DONE : S_LOAD;
            else if (start_dump)
               w_next = (w_clamp == '0) ? S_DONE : S_DUMP_SEL;
         end
         S_LOAD:     if (r_rem == '0) w_next = S_DONE;
         S_DUMP_SEL: w_next = S_DUMP_OUT;
         S_DUMP_OUT: if (w_m_fire) w_next = (r_rem == C_REM_ONE) ? S_DONE : S_DUMP_SEL;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_idx        <= '0;
         r_rem        <= '0;
         r_bus_in     <= '0;
         r_put_in     <= '0;
         r_ld_write   <= 1'b0;
         r_control_in <= '0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
      end else begin
         // Write strobe and input-mux select live for exactly one cycle.
         r_ld_write   <= 1'b0;
         r_control_in <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (start_load || start_dump) begin
                  r_idx <= base_idx;
                  r_rem <= w_clamp;
               end
            end
            S_LOAD: begin
               if (w_s_fire) begin
                  r_bus_in     <= bus.s_data;
                  r_put_in     <= r_idx;
                  r_ld_write   <= 1'b1;
                  r_control_in <= C_SEL_BUS;
                  r_idx        <= r_idx + C_IDX_ONE;
                  r_rem        <= r_rem - C_REM_ONE;
               end
            end
            S_DUMP_SEL: begin
               // Read selects were on the bus all cycle; capture the result.
               r_m_data  <= bus.pe_bus_out;
               r_m_valid <= 1'b1;
            end
            S_DUMP_OUT: begin
               if (w_m_fire) begin
                  r_m_valid <= 1'b0;
                  r_idx     <= r_idx + C_IDX_ONE;
                  r_rem     <= r_rem - C_REM_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy                  = (r_state != S_IDLE);
   assign done                  = (r_state == S_DONE);
   assign bus.s_ready           = w_s_ready;
   assign bus.m_valid           = r_m_valid;
   assign bus.m_data            = r_m_data;
   assign bus.pe_bus_in         = r_bus_in;
   assign bus.pe_control_in     = r_control_in;
   assign bus.pe_control_put_in = r_put_in;
   assign bus.pe_ld             = (r_state != S_IDLE);
   assign bus.pe_ld_write       = r_ld_write;
   assign bus.pe_control_send   = (r_state == S_DUMP_SEL) ? r_idx : '0;
   assign bus.pe_control_out    = (r_state == S_DUMP_SEL) ? C_SEL_BUS : 9'd0;
endmodule
`default_nettype wire

// File: tb/tb_pe_reg_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pe_reg_loader
// Description : Self-checking bench for pe_reg_loader with a behavioural PE
//               register file that captures writes on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pe_reg_loader;
   localparam logic [8:0] SEL = 9'b000010000;

   typedef struct {
      int          cyc;
      logic [5:0]  idx;
      logic [31:0] data;
      logic [8:0]  ctl;
   } wr_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start_load = 1'b0;
   logic        start_dump = 1'b0;
   logic [5:0]  base_idx = '0;
   logic [6:0]  count = '0;
   logic        busy;
   logic        done;

   pe_reg_loader_if #(.DW(32), .AW(6)) bus_if ();

   pe_reg_loader #(.DW(32), .AW(6)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start_load (start_load),
      .start_dump (start_dump),
      .base_idx   (base_idx),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .bus        (bus_if)
   );

   always #5 CLK = ~CLK;

   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   int          conflicts = 0;
   logic [31:0] pe_mem [64];
   wr_t         obs_wr[$];
   int          obs_done[$];
   logic [5:0]  obs_send[$];
   logic [31:0] obs_m[$];
   wr_t         exp_wr[$];
   logic [5:0]  exp_send[$];
   logic [31:0] exp_m[$];
   logic [31:0] in_words[$];
   wr_t         mon_w;

   always @(posedge CLK) cyc <= cyc + 1;

   assign bus_if.pe_bus_out = (bus_if.pe_control_out == SEL) ? pe_mem[bus_if.pe_control_send] : 32'h0;

   // PE register file model and bus observer.
   always @(negedge CLK) begin
      if (bus_if.pe_ld_write) begin
         if (bus_if.pe_ld && bus_if.pe_control_in == SEL)
            pe_mem[bus_if.pe_control_put_in] <= bus_if.pe_bus_in;
         mon_w.cyc  = cyc;
         mon_w.idx  = bus_if.pe_control_put_in;
         mon_w.data = bus_if.pe_bus_in;
         mon_w.ctl  = bus_if.pe_control_in;
         obs_wr.push_back(mon_w);
         if (bus_if.pe_control_out != 9'd0) conflicts <= conflicts + 1;
      end
      if (done) obs_done.push_back(cyc);
      if (bus_if.pe_control_out == SEL) obs_send.push_back(bus_if.pe_control_send);
      if (bus_if.m_valid && bus_if.m_ready) obs_m.push_back(bus_if.m_data);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Starts a load and streams in_words; expected writes are scoreboarded at
   // each accepted handshake with the bench's own index sequence.
   task automatic feed_load(input logic [5:0] b, input logic [6:0] c, input bit alt,
                            input bit both, output int s_cyc);
      logic [5:0] idx = b;
      wr_t        e;
      int         g = 0;
      s_cyc = cyc;
      start_load = 1'b1; start_dump = both; base_idx = b; count = c;
      tick();
      start_load = 1'b0; start_dump = 1'b0;
      while (in_words.size() > 0 && g < 200) begin
         bus_if.s_valid = !alt || (g % 2 == 0);
         bus_if.s_data  = in_words[0];
         start_load = both && (g == 1);
         start_dump = both && (g == 1);
         base_idx   = (both && g == 1) ? 6'd50 : b;
         @(negedge CLK);
         if (bus_if.s_valid && bus_if.s_ready) begin
            e.cyc = cyc + 1; e.idx = idx; e.data = bus_if.s_data; e.ctl = SEL;
            exp_wr.push_back(e);
            idx = idx + 6'd1;
            void'(in_words.pop_front());
         end
         tick();
         g++;
      end
      bus_if.s_valid = 1'b0; start_load = 1'b0; start_dump = 1'b0;
   endtask

   task automatic wait_done(input int n0, output bit ok);
      int g = 0;
      while (obs_done.size() <= n0 && g < 300) begin
         tick();
         g++;
      end
      ok = (obs_done.size() > n0);
   endtask

   task automatic test_reset();
      logic [207:0] v;
      RST_N = 1'b0;
      repeat (3) tick();
      @(negedge CLK);
      v = {busy, done, bus_if.s_ready, bus_if.m_valid, bus_if.m_data, bus_if.pe_bus_in,
           bus_if.pe_control_in, bus_if.pe_control_put_in, bus_if.pe_ld, bus_if.pe_ld_write,
           bus_if.pe_control_send, bus_if.pe_control_out, 96'h0};
      checks++; if (v !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", v); end
      RST_N = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || bus_if.pe_ld !== 1'b0) begin
         fails++; $display("FAIL reset_idle: busy=%b pe_ld=%b want 0 0", busy, bus_if.pe_ld); end
   endtask

   task automatic test_load_basic();
      int w0 = obs_wr.size(); int d0 = obs_done.size(); int s; bit ok; wr_t e; wr_t o;
      in_words = '{32'hA1, 32'hB2, 32'hC3, 32'hEE, 32'hFF};
      feed_load(6'd5, 7'd3, 1'b0, 1'b0, s);
      wait_done(d0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL load_basic_done_timeout: got none want done"); end
      checks++; if (exp_wr.size() != 3) begin fails++; $display("FAIL load_basic_accepts: got %0d want 3", exp_wr.size()); end
      checks++; if (obs_wr.size() - w0 != 3) begin fails++; $display("FAIL load_basic_writes: got %0d want 3", obs_wr.size() - w0); end
      for (int i = 0; i < 3 && exp_wr.size() > 0 && w0 + i < obs_wr.size(); i++) begin
         e = exp_wr.pop_front(); o = obs_wr[w0 + i];
         checks++; if (o.idx !== e.idx || o.data !== e.data || o.ctl !== e.ctl || o.cyc != e.cyc) begin
            fails++; $display("FAIL load_basic_wr%0d: got idx=%0d data=%h ctl=%b cyc=%0d want idx=%0d data=%h ctl=%b cyc=%0d",
                              i, o.idx, o.data, o.ctl, o.cyc, e.idx, e.data, e.ctl, e.cyc); end
      end
      if (obs_wr.size() - w0 == 3 && obs_done.size() > d0) begin
         checks++; if (obs_wr[w0+2].cyc - obs_wr[w0].cyc != 2 || obs_done[d0] != obs_wr[w0+2].cyc + 1) begin
            fails++; $display("FAIL load_basic_timing: got first=%0d last=%0d done=%0d want last=first+2 done=last+1",
                              obs_wr[w0].cyc, obs_wr[w0+2].cyc, obs_done[d0]); end
      end
      checks++; if (obs_done.size() - d0 != 1) begin fails++; $display("FAIL load_basic_done_count: got %0d want 1", obs_done.size() - d0); end
      exp_wr.delete();
   endtask

   task automatic test_load_wrap();
      int w0 = obs_wr.size(); int d0 = obs_done.size(); int s; bit ok; wr_t e; wr_t o;
      logic [5:0] want_idx [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
      in_words = '{32'h0000_0062, 32'h0000_0063, 32'h0000_0000, 32'h0000_0001};
      feed_load(6'd62, 7'd4, 1'b1, 1'b0, s);
      wait_done(d0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL load_wrap_done_timeout: got none want done"); end
      checks++; if (obs_wr.size() - w0 != 4) begin fails++; $display("FAIL load_wrap_writes: got %0d want 4", obs_wr.size() - w0); end
      for (int i = 0; i < 4 && exp_wr.size() > 0 && w0 + i < obs_wr.size(); i++) begin
         e = exp_wr.pop_front(); o = obs_wr[w0 + i];
         checks++; if (o.idx !== want_idx[i] || o.idx !== e.idx || o.data !== e.data || o.cyc != e.cyc) begin
            fails++; $display("FAIL load_wrap_wr%0d: got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                              i, o.idx, o.data, o.cyc, want_idx[i], e.data, e.cyc); end
      end
      exp_wr.delete();
   endtask

   task automatic test_dump_backpressure();
      int d0; int m0; int n0; int s; bit ok; int stall = 0; int g = 0; int nrx = 0;
      logic [31:0] em; logic [5:0] es;
      in_words = '{32'd11, 32'd22, 32'd33};
      d0 = obs_done.size();
      feed_load(6'd10, 7'd3, 1'b0, 1'b0, s);
      wait_done(d0, ok);
      exp_wr.delete();
      d0 = obs_done.size(); m0 = obs_m.size(); n0 = obs_send.size();
      exp_m = '{32'd11, 32'd22, 32'd33};
      exp_send = '{6'd10, 6'd11, 6'd12};
      bus_if.m_ready = 1'b1;
      start_dump = 1'b1; base_idx = 6'd10; count = 7'd3;
      tick();
      start_dump = 1'b0;
      while (nrx < 3 && g < 100) begin
         if (nrx == 1 && stall < 3 && (stall > 0 || bus_if.m_valid)) begin
            bus_if.m_ready = 1'b0;
            stall++;
            checks++; if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 32'd22) begin
               fails++; $display("FAIL dump_hold%0d: got valid=%b data=%0d want valid=1 data=22",
                                 stall, bus_if.m_valid, bus_if.m_data); end
         end else begin
            bus_if.m_ready = 1'b1;
         end
         @(negedge CLK);
         if (bus_if.m_valid && bus_if.m_ready) nrx++;
         tick();
         g++;
      end
      bus_if.m_ready = 1'b0;
      wait_done(d0, ok);
      checks++; if (!ok || nrx != 3) begin fails++; $display("FAIL dump_timeout: got words=%0d want 3", nrx); end
      checks++; if (obs_m.size() - m0 != 3 || obs_send.size() - n0 != 3) begin
         fails++; $display("FAIL dump_counts: got words=%0d sends=%0d want 3 3", obs_m.size() - m0, obs_send.size() - n0); end
      for (int i = 0; i < 3 && exp_m.size() > 0 && m0 + i < obs_m.size() && n0 + i < obs_send.size(); i++) begin
         em = exp_m.pop_front(); es = exp_send.pop_front();
         checks++; if (obs_m[m0+i] !== em || obs_send[n0+i] !== es) begin
            fails++; $display("FAIL dump_word%0d: got data=%0d send=%0d want data=%0d send=%0d",
                              i, obs_m[m0+i], obs_send[n0+i], em, es); end
      end
      checks++; if (bus_if.m_valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL dump_end: got m_valid=%b busy=%b want 0 0", bus_if.m_valid, busy); end
      exp_m.delete(); exp_send.delete();
   endtask

   task automatic test_count_edges();
      int w0 = obs_wr.size(); int d0 = obs_done.size(); int s; bit ok; wr_t e; wr_t o; int bad = 0;
      in_words.delete();
      feed_load(6'd7, 7'd0, 1'b0, 1'b0, s);
      wait_done(d0, ok);
      repeat (3) tick();
      checks++; if (!ok || obs_done[d0] != s + 1) begin
         fails++; $display("FAIL count0_done: got ok=%b cyc=%0d want cyc=%0d", ok, ok ? obs_done[d0] : -1, s + 1); end
      checks++; if (obs_wr.size() != w0) begin fails++; $display("FAIL count0_writes: got %0d want 0", obs_wr.size() - w0); end
      w0 = obs_wr.size(); d0 = obs_done.size();
      for (int i = 0; i < 100; i++) in_words.push_back(32'h1000 + i);
      feed_load(6'd0, 7'd100, 1'b0, 1'b0, s);
      wait_done(d0, ok);
      checks++; if (!ok || exp_wr.size() != 64 || obs_wr.size() - w0 != 64) begin
         fails++; $display("FAIL count100_writes: got accepts=%0d writes=%0d want 64 64", exp_wr.size(), obs_wr.size() - w0); end
      for (int i = 0; i < 64 && exp_wr.size() > 0 && w0 + i < obs_wr.size(); i++) begin
         e = exp_wr.pop_front(); o = obs_wr[w0 + i];
         if (o.idx !== e.idx || o.data !== e.data || o.cyc != e.cyc) bad++;
      end
      checks++; if (bad != 0) begin fails++; $display("FAIL count100_content: got %0d bad writes want 0", bad); end
      checks++; if (pe_mem[63] !== 32'h103F) begin fails++; $display("FAIL count100_mem63: got %h want 0000103f", pe_mem[63]); end
      exp_wr.delete(); in_words.delete();
   endtask

   task automatic test_simultaneous();
      int w0 = obs_wr.size(); int d0 = obs_done.size(); int n0 = obs_send.size(); int s; bit ok; wr_t e; wr_t o;
      in_words = '{32'h5A, 32'h5B};
      feed_load(6'd30, 7'd2, 1'b0, 1'b1, s);
      wait_done(d0, ok);
      repeat (10) tick();
      checks++; if (!ok || obs_done.size() - d0 != 1) begin
         fails++; $display("FAIL simul_done: got %0d want 1", obs_done.size() - d0); end
      checks++; if (obs_wr.size() - w0 != 2 || obs_send.size() != n0) begin
         fails++; $display("FAIL simul_ops: got writes=%0d reads=%0d want 2 0", obs_wr.size() - w0, obs_send.size() - n0); end
      for (int i = 0; i < 2 && exp_wr.size() > 0 && w0 + i < obs_wr.size(); i++) begin
         e = exp_wr.pop_front(); o = obs_wr[w0 + i];
         checks++; if (o.idx !== e.idx || o.data !== e.data) begin
            fails++; $display("FAIL simul_wr%0d: got idx=%0d data=%h want idx=%0d data=%h", i, o.idx, o.data, e.idx, e.data); end
      end
      exp_wr.delete();
   endtask

   task automatic test_reset_mid();
      logic [207:0] v;
      start_load = 1'b1; base_idx = 6'd20; count = 7'd2;
      tick();
      start_load = 1'b0;
      bus_if.s_valid = 1'b1; bus_if.s_data = 32'hCAFE_0001;
      tick();
      bus_if.s_data = 32'hCAFE_0002; RST_N = 1'b0;
      tick();
      @(negedge CLK);
      v = {busy, done, bus_if.s_ready, bus_if.m_valid, bus_if.m_data, bus_if.pe_bus_in,
           bus_if.pe_control_in, bus_if.pe_control_put_in, bus_if.pe_ld, bus_if.pe_ld_write,
           bus_if.pe_control_send, bus_if.pe_control_out, 96'h0};
      checks++; if (v !== '0) begin fails++; $display("FAIL rstmid_outputs: got %h want 0", v); end
      RST_N = 1'b1; bus_if.s_valid = 1'b0;
      repeat (3) tick();
      checks++; if (pe_mem[20] !== 32'hCAFE_0001 || pe_mem[21] !== 32'h0000_1015) begin
         fails++; $display("FAIL rstmid_mem: got r20=%h r21=%h want cafe0001 00001015", pe_mem[20], pe_mem[21]); end
      checks++; if (conflicts != 0) begin fails++; $display("FAIL rw_conflict: got %0d want 0", conflicts); end
   endtask

   initial begin
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      bus_if.m_ready = 1'b0;
      test_reset();
      test_load_basic();
      test_load_wrap();
      test_dump_backpressure();
      test_count_edges();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
